ex_mem_pipe_reg: RTL

EX/MEM pipeline register. It captures the execute-stage datapath results and the MEM/WB control bits on each clock and presents them to the memory stage. It supports pipeline stall (hold) and flush (bubble insertion on taken branch or jump), and tracks a valid bit per slot. It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/ex_mem_pipe_reg_if.sv | 68 ++++++
 rtl/ex_mem_pipe_reg.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_reg_if.sv
// EX/MEM pipeline register bus: execute-stage inputs, pipeline control,
// memory-stage outputs and the performance-debug event counters.
interface ex_mem_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  // Pipeline control from the hazard / branch logic
  logic              stall;
  logic              flush;

  // Execute-stage slot
  logic              ex_valid;
  logic              ex_zero;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_rt;
  logic [DATA_W-1:0] ex_branch_addr;
  logic [DATA_W-1:0] ex_jump_addr;
  logic [DATA_W-1:0] ex_reg_dest;
  logic              ex_branch;
  logic              ex_mem_write;
  logic              ex_mem_read;
  logic              ex_jump;
  logic              ex_reg_write;
  logic              ex_mem_to_reg;

  // Memory-stage slot
  logic              mem_valid;
  logic              mem_zero;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_rt;
  logic [DATA_W-1:0] mem_branch_addr;
  logic [DATA_W-1:0] mem_jump_addr;
  logic [DATA_W-1:0] mem_reg_dest;
  logic              mem_branch;
  logic              mem_mem_write;
  logic              mem_mem_read;
  logic              mem_jump;
  logic              mem_reg_write;
  logic              mem_mem_to_reg;

  // Event counters
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  // Upstream side: drives the EX slot and pipeline control
  modport master (
    output stall, flush,
    output ex_valid, ex_zero, ex_alu_result, ex_rt, ex_branch_addr,
           ex_jump_addr, ex_reg_dest, ex_branch, ex_mem_write,
           ex_mem_read, ex_jump, ex_reg_write, ex_mem_to_reg,
    input  mem_valid, mem_zero, mem_alu_result, mem_rt, mem_branch_addr,
           mem_jump_addr, mem_reg_dest, mem_branch, mem_mem_write,
           mem_mem_read, mem_jump, mem_reg_write, mem_mem_to_reg,
    input  stall_count, flush_count
  );

  // Pipeline register side: consumes the EX slot, presents the MEM slot
  modport slave (
    input  stall, flush,
    input  ex_valid, ex_zero, ex_alu_result, ex_rt, ex_branch_addr,
           ex_jump_addr, ex_reg_dest, ex_branch, ex_mem_write,
           ex_mem_read, ex_jump, ex_reg_write, ex_mem_to_reg,
    output mem_valid, mem_zero, mem_alu_result, mem_rt, mem_branch_addr,
           mem_jump_addr, mem_reg_dest, mem_branch, mem_mem_write,
           mem_mem_read, mem_jump, mem_reg_write, mem_mem_to_reg,
    output stall_count, flush_count
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with stall (hold), flush (bubble insertion),
// per-slot valid tracking and saturating stall / flush event counters.
// Edge priority: rst > flush > stall > load. All outputs come straight
// from flops; there is no combinational path from any input to any output.
module ex_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  ex_mem_pipe_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // One pipeline slot: valid, datapath fields and MEM/WB controls
  typedef struct packed {
    logic              valid;
    logic              zero;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] rt;
    logic [DATA_W-1:0] branch_addr;
    logic [DATA_W-1:0] jump_addr;
    logic [DATA_W-1:0] reg_dest;
    logic              branch;
    logic              mem_write;
    logic              mem_read;
    logic              jump;
    logic              reg_write;
    logic              mem_to_reg;
  } slot_t;

  slot_t            slot_r;
  slot_t            in_slot_s;
  slot_t            slot_next_s;
  logic [CNT_W-1:0] stall_count_r;
  logic [CNT_W-1:0] flush_count_r;
  logic [CNT_W-1:0] stall_count_next_s;
  logic [CNT_W-1:0] flush_count_next_s;
  logic             stall_event_s;
  logic             flush_event_s;

  // Saturating increment: holds at all-ones instead of wrapping to zero
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == CNT_MAX) begin
      result = CNT_MAX;
    end else begin
      result = value + CNT_ONE;
    end
    return result;
  endfunction

  // Gather the EX slot; an invalid slot never carries live control bits
  always_comb begin
    in_slot_s             = '0;
    in_slot_s.valid       = bus.ex_valid;
    in_slot_s.zero        = bus.ex_zero;
    in_slot_s.alu_result  = bus.ex_alu_result;
    in_slot_s.rt          = bus.ex_rt;
    in_slot_s.branch_addr = bus.ex_branch_addr;
    in_slot_s.jump_addr   = bus.ex_jump_addr;
    in_slot_s.reg_dest    = bus.ex_reg_dest;
    if (bus.ex_valid) begin
      in_slot_s.branch     = bus.ex_branch;
      in_slot_s.mem_write  = bus.ex_mem_write;
      in_slot_s.mem_read   = bus.ex_mem_read;
      in_slot_s.jump       = bus.ex_jump;
      in_slot_s.reg_write  = bus.ex_reg_write;
      in_slot_s.mem_to_reg = bus.ex_mem_to_reg;
    end else begin
      in_slot_s.branch     = 1'b0;
      in_slot_s.mem_write  = 1'b0;
      in_slot_s.mem_read   = 1'b0;
      in_slot_s.jump       = 1'b0;
      in_slot_s.reg_write  = 1'b0;
      in_slot_s.mem_to_reg = 1'b0;
    end
  end

  // Select the next slot: flush inserts an all-zero bubble, stall holds
  always_comb begin
    slot_next_s = slot_r;
    if (bus.flush) begin
      slot_next_s = '0;
    end else if (bus.stall) begin
      slot_next_s = slot_r;
    end else begin
      slot_next_s = in_slot_s;
    end
  end

  // Classify the edge for the counters; a flushed stall is not a stall cycle
  always_comb begin
    flush_event_s = 1'b0;
    stall_event_s = 1'b0;
    if (bus.flush) begin
      flush_event_s = 1'b1;
      stall_event_s = 1'b0;
    end else if (bus.stall) begin
      flush_event_s = 1'b0;
      stall_event_s = 1'b1;
    end else begin
      flush_event_s = 1'b0;
      stall_event_s = 1'b0;
    end
  end

  // Next counter values, saturating at all-ones
  always_comb begin
    stall_count_next_s = stall_count_r;
    flush_count_next_s = flush_count_r;
    if (stall_event_s) begin
      stall_count_next_s = sat_inc(stall_count_r);
    end else begin
      stall_count_next_s = stall_count_r;
    end
    if (flush_event_s) begin
      flush_count_next_s = sat_inc(flush_count_r);
    end else begin
      flush_count_next_s = flush_count_r;
    end
  end

  // Slot register; reset overrides flush and stall on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_r <= '0;
    end else begin
      slot_r <= slot_next_s;
    end
  end

  // Event counters; cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_r <= '0;
      flush_count_r <= '0;
    end else begin
      stall_count_r <= stall_count_next_s;
      flush_count_r <= flush_count_next_s;
    end
  end

  // Present the registered slot to the memory stage
  assign bus.mem_valid       = slot_r.valid;
  assign bus.mem_zero        = slot_r.zero;
  assign bus.mem_alu_result  = slot_r.alu_result;
  assign bus.mem_rt          = slot_r.rt;
  assign bus.mem_branch_addr = slot_r.branch_addr;
  assign bus.mem_jump_addr   = slot_r.jump_addr;
  assign bus.mem_reg_dest    = slot_r.reg_dest;
  assign bus.mem_branch      = slot_r.branch;
  assign bus.mem_mem_write   = slot_r.mem_write;
  assign bus.mem_mem_read    = slot_r.mem_read;
  assign bus.mem_jump        = slot_r.jump;
  assign bus.mem_reg_write   = slot_r.reg_write;
  assign bus.mem_mem_to_reg  = slot_r.mem_to_reg;
  assign bus.stall_count     = stall_count_r;
  assign bus.flush_count     = flush_count_r;

endmodule
